d26_arb: RTL and testbench

D26_ARB -- requirements
Module: d26_arb

---
 rtl/d26_arb_pkg.sv | 21 ++
 rtl/d26_rr_pick.sv | 31 +++
 rtl/d26_arb.sv | 175 +++++++++++++++++
 tb/tb_d26_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/d26_arb_pkg.sv
// Shared types and defaults for the d26 engine arbiter.
// The watchdog counter width is derived here so every build agrees on it.
package d26_arb_pkg;

  localparam int D26_NREQ_DEF    = 4;
  localparam int D26_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_KILL = 2'd2
  } d26_state_e;

  // Width needed to hold a count of 0..timeout inclusive.
  function automatic int d26_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int D26_CNT_W = d26_cnt_width(D26_TIMEOUT_DEF);

endpackage

// File: rtl/d26_rr_pick.sv
// Combinational round-robin picker: lowest set request at or after ptr,
// wrapping modulo NREQ. Holds no state.
module d26_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [IW-1:0]     off_s;
  logic [IW:0]       sum_s;

  // Rotate requests so ptr sits at bit 0, find the first hit, then undo the rotation.
  always_comb begin
    dbl_s = {req, req};
    rot_s = dbl_s[ptr +: NREQ];
    valid = |rot_s;
    off_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? IW'(k) : off_s;
    end
    sum_s  = {1'b0, ptr} + {1'b0, off_s};
    winner = (sum_s >= (IW+1)'(NREQ)) ? IW'(sum_s - (IW+1)'(NREQ)) : sum_s[IW-1:0];
  end

endmodule

// File: rtl/d26_arb.sv
// d26_arb: round-robin arbiter in front of the shared d26 transaction engine.
// Define D26_ARB_TIMEOUT_EN to add the BUSY watchdog (kill/err and the KILL state).
module d26_arb
  import d26_arb_pkg::*;
#(
  parameter int NREQ    = D26_NREQ_DEF,
  parameter int TIMEOUT = D26_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] err,
  output logic            go,
  output logic            kill,
  input  logic            endtx,
  output logic            busy
);

  localparam int IW = $clog2(NREQ);
  // An out-of-range configuration never arms, so the arbiter stays idle.
  localparam logic CFG_OK = ((NREQ >= 2) && (NREQ <= 8) && (TIMEOUT >= 1)) ? 1'b1 : 1'b0;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
    return (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
  endfunction

  d26_state_e      state_r, state_s;
  logic [IW-1:0]   ptr_r, ptr_s;
  logic [IW-1:0]   win_r, win_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [NREQ-1:0] done_r, done_s;
  logic            go_r, go_s;
  logic            busy_r, busy_s;
  logic            arm_r;
  logic [IW-1:0]   pick_win_s;
  logic            pick_valid_s;

`ifdef D26_ARB_TIMEOUT_EN
  localparam int CW = d26_cnt_width(TIMEOUT);
  logic [CW-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic [NREQ-1:0] err_r, err_s;
  logic            kill_r, kill_s;
`endif

  d26_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .winner (pick_win_s),
    .valid  (pick_valid_s)
  );

  // Next-state and output decode; pulses default low, held outputs default to their register.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    win_s   = win_r;
    gnt_s   = gnt_r;
    busy_s  = busy_r;
    done_s  = '0;
    go_s    = 1'b0;
`ifdef D26_ARB_TIMEOUT_EN
    err_s     = '0;
    kill_s    = 1'b0;
    cnt_inc_s = cnt_r + CW'(1);
    cnt_s     = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (arm_r && pick_valid_s) begin
          state_s = ST_BUSY;
          win_s   = pick_win_s;
          gnt_s   = onehot(pick_win_s);
          go_s    = 1'b1;
          busy_s  = 1'b1;
`ifdef D26_ARB_TIMEOUT_EN
          cnt_s   = '0;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // endtx is ignored while go is still up.
        if (endtx && !go_r) begin
          state_s = ST_IDLE;
          done_s  = onehot(win_r);
          gnt_s   = '0;
          busy_s  = 1'b0;
          ptr_s   = ptr_after(win_r);
        end
`ifdef D26_ARB_TIMEOUT_EN
        else if (cnt_inc_s == CW'(TIMEOUT)) begin
          state_s = ST_KILL;
          kill_s  = 1'b1;
          err_s   = onehot(win_r);
          gnt_s   = '0;
          busy_s  = 1'b0;
          ptr_s   = ptr_after(win_r);
        end else begin
          cnt_s = cnt_inc_s;
        end
`else
        else begin
          state_s = ST_BUSY;
        end
`endif
      end
`ifdef D26_ARB_TIMEOUT_EN
      ST_KILL: begin
        state_s = ST_IDLE;
      end
`endif
      default: begin
        state_s = ST_IDLE;
        gnt_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      win_r   <= '0;
      gnt_r   <= '0;
      done_r  <= '0;
      go_r    <= 1'b0;
      busy_r  <= 1'b0;
      arm_r   <= 1'b0;
`ifdef D26_ARB_TIMEOUT_EN
      cnt_r   <= '0;
      err_r   <= '0;
      kill_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      win_r   <= win_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      go_r    <= go_s;
      busy_r  <= busy_s;
      arm_r   <= CFG_OK;
`ifdef D26_ARB_TIMEOUT_EN
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      kill_r  <= kill_s;
`endif
    end
  end

  assign gnt  = gnt_r;
  assign done = done_r;
  assign go   = go_r;
  assign busy = busy_r;
`ifdef D26_ARB_TIMEOUT_EN
  assign err  = err_r;
  assign kill = kill_r;
`else
  assign err  = '0;
  assign kill = 1'b0;
`endif

endmodule

// File: tb/tb_d26_arb.sv
// Bench for d26_arb: directed scenarios then random traffic, all checked against
// a transaction-level reference model (owner index, age, pointer as integers).
module tb_d26_arb;

  localparam int N  = 4;
  localparam int TO = 16;
`ifdef D26_ARB_TIMEOUT_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         endtx = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt, done, err;
  logic         go, kill, busy;

  d26_arb #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .done(done), .err(err),
    .go(go), .kill(kill), .endtx(endtx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: owner = -1 when nobody holds the engine
  int           m_owner, m_ptr, m_age;
  bit           m_armed, m_killing;
  logic [N-1:0] e_gnt, e_done, e_err;
  logic         e_go, e_kill, e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".gnt"},  32'(gnt),  32'(e_gnt));
    chk({pfx, ".done"}, 32'(done), 32'(e_done));
    chk({pfx, ".err"},  32'(err),  32'(e_err));
    chk({pfx, ".go"},   32'(go),   32'(e_go));
    chk({pfx, ".kill"}, 32'(kill), 32'(e_kill));
    chk({pfx, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_age = 0; m_armed = 1'b0; m_killing = 1'b0;
    e_gnt = '0; e_done = '0; e_err = '0; e_go = 1'b0; e_kill = 1'b0; e_busy = 1'b0;
  endtask

  // One clock edge of the arbitration rules, given the inputs seen at that edge.
  task automatic model_step(input logic [N-1:0] r, input logic et);
    int w;
    e_done = '0; e_err = '0; e_go = 1'b0; e_kill = 1'b0;
    if (m_killing) begin
      m_killing = 1'b0;
    end else if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (m_armed && w >= 0) begin
        m_owner = w; m_age = 0; e_go = 1'b1;
      end
    end else begin
      if (m_age > 0 && et) begin
        e_done = N'(1) << m_owner;
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end else if (WDOG && (m_age + 1 == TO)) begin
        e_kill = 1'b1; e_err = N'(1) << m_owner;
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_killing = 1'b1;
      end else begin
        m_age++;
      end
    end
    m_armed = 1'b1;
    e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_busy = (m_owner >= 0);
  endtask

  task automatic tick(input logic [N-1:0] r, input logic et);
    req = r; endtx = et;
    @(posedge clk);
    model_step(r, et);
    cyc++;
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset(input int ncyc);
    req = '0; endtx = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_now");
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic wait_go(input string tag, input int bound, input logic [N-1:0] r);
    int k = 0;
    while (go !== 1'b1 && k < bound) begin
      tick(r, 1'b0);
      k++;
    end
    chk(tag, 32'(go), 32'd1);
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int last_go;
    logic [N-1:0] r;

    #2;
    // reset state, release latency, basic transaction, ignored endtx
    do_reset(2);
    tick(4'b0010, 1'b1);
    chk("release_no_go", 32'(go), 32'd0);
    tick(4'b0010, 1'b0);
    chk("t33_gnt", 32'(gnt), 32'h2);
    chk("t33_go", 32'(go), 32'd1);
    tick(4'b0010, 1'b1);
    chk("endtx_in_go_cycle", 32'(done), 32'd0);
    chk("still_busy", 32'(busy), 32'd1);
    repeat (4) tick(4'b1101, 1'b0);
    tick(4'b0000, 1'b1);
    chk("t33_done", 32'(done), 32'h2);
    chk("t33_busy", 32'(busy), 32'd0);
    tick(4'b0000, 1'b1);
    chk("endtx_idle", 32'(done), 32'd0);

    // full contention: order and go-to-go spacing
    do_reset(1);
    last_go = 0;
    for (int k = 0; k < 5; k++) begin
      wait_go("t34_go", 10, 4'b1111);
      chk("t34_order", 32'(gnt), 32'(N'(1) << exp_order[k]));
      if (k > 0) chk("t34_spacing", 32'(cyc - last_go), 32'd5);
      last_go = cyc;
      repeat (3) tick(4'b1111, 1'b0);
      tick(4'b1111, 1'b1);
    end

    // wrap-around from ptr 3
    wait_go("t35_go2", 5, 4'b0100);
    chk("t35_gnt2", 32'(gnt), 32'h4);
    tick(4'b0100, 1'b1);
    tick(4'b1001, 1'b1);
    wait_go("t35_go3", 5, 4'b1001);
    chk("t35_gnt3", 32'(gnt), 32'h8);
    tick(4'b1001, 1'b0);
    tick(4'b1001, 1'b1);
    wait_go("t35_go0", 5, 4'b1001);
    chk("t35_gnt0", 32'(gnt), 32'h1);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);

    // reset in the middle of a grant
    wait_go("t37_go", 5, 4'b0100);
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b0);
    chk("t37_pre_gnt", 32'(gnt), 32'h4);
    do_reset(2);
    chk("t37_gnt_cleared", 32'(gnt), 32'd0);
    wait_go("t37_regrant", 5, 4'b0100);
    chk("t37_gnt", 32'(gnt), 32'h4);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);

`ifdef D26_ARB_TIMEOUT_EN
    // watchdog expiry, endtx during KILL, and endtx on the final cycle
    wait_go("t36_go", 5, 4'b0010);
    repeat (15) tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    chk("t36_kill", 32'(kill), 32'd1);
    chk("t36_err", 32'(err), 32'h2);
    tick(4'b0000, 1'b1);
    chk("t36_kill_pulse", 32'(kill), 32'd0);
    chk("t36_no_done_kill", 32'(done), 32'd0);
    wait_go("t36_go_b", 5, 4'b0010);
    repeat (15) tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
    chk("t36_done_wins", 32'(done), 32'h2);
    chk("t36_no_kill", 32'(kill), 32'd0);
`else
    // no watchdog: BUSY waits indefinitely
    wait_go("t30_go", 5, 4'b0010);
    repeat (30) tick(4'b0000, 1'b0);
    chk("t30_busy", 32'(busy), 32'd1);
    chk("t30_kill", 32'(kill), 32'd0);
    tick(4'b0000, 1'b1);
    chk("t30_done", 32'(done), 32'h2);
`endif

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = '0;
      tick(r, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 149) == 0) do_reset(1 + $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
